transmitter: RTL
================

TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 Parameter TX_FIFO_LOAD_W, default 10: width of txfifo_load, the TX FIFO occupancy count in bytes.
REQ-002 Parameter TX_FIFO_DEPTH, default 512: TX FIFO capacity in bytes, at most 2**TX_FIFO_LOAD_W.
REQ-003 Port clk, input, 1: sole clock, all logic on posedge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port msg_valid, input, 1: a message request is presented.
REQ-006 Port msg_ready, output, 1: the block can accept a message.
REQ-007 Port msg_code, input, 16: message code.
REQ-008 Port msg_data, input, 32: message payload.
REQ-009 Port txfifo_load, input, TX_FIFO_LOAD_W: current TX FIFO occupancy.
REQ-010 Port txfifo_full, input, 1: TX FIFO full; a write in that cycle is not permitted.
REQ-011 Port txfifo_wr, output, 1: byte write strobe to the TX FIFO.
REQ-012 Port txfifo_data, output, 8: byte to write.
REQ-013 Port busy, output, 1: a frame is held or being sent.
REQ-014 Port frames_sent, output, 16: count of completed frames, wrapping.

Function
REQ-015 Frame byte order SHALL be AA, code[15:8], code[7:0], data[31:24], data[23:16], data[15:8], data[7:0], 55, giving FRAME_LEN = 8.
REQ-016 FSM states SHALL be IDLE, WAIT_SPACE and SEND.
REQ-017 IDLE: msg_ready = 1; on msg_valid && msg_ready, register msg_code and msg_data, clear the byte index, and go to WAIT_SPACE.
REQ-018 msg_ready SHALL be 0 in all states except IDLE; while not ready, input changes are ignored.
REQ-019 WAIT_SPACE: go to SEND when (TX_FIFO_DEPTH - txfifo_load) >= FRAME_LEN and txfifo_full = 0; otherwise hold.
REQ-020 Free-space arithmetic SHALL use TX_FIFO_LOAD_W+1 bits so it cannot wrap.
REQ-021 SEND: txfifo_wr = ~txfifo_full, combinational.
REQ-022 SEND: txfifo_data = the byte selected by the registered index.
REQ-023 The byte index SHALL advance only on cycles with txfifo_wr = 1.
REQ-024 When txfifo_full is asserted mid-frame, the current byte SHALL be held and no byte skipped or duplicated.
REQ-025 When the last byte is written, go to IDLE and increment frames_sent in the same cycle, with frames_sent wrapping FFFF->0000.
REQ-026 txfifo_wr SHALL be 0 outside SEND; txfifo_data SHALL be 00 when txfifo_wr = 0.
REQ-027 busy SHALL be 1 in WAIT_SPACE and SEND.
REQ-028 Latency: acceptance in cycle N gives the first write no earlier than N+2; an unstalled frame occupies 8 consecutive write cycles.
REQ-029 Back-to-back: msg_ready SHALL reassert in the cycle after the last byte is written; the minimum gap between frames is 2 cycles.

Reset
REQ-030 rst SHALL force IDLE and clear frames_sent, the byte index and the captured code and data.
REQ-031 Output values during and after reset SHALL be msg_ready = 1, txfifo_wr = 0, txfifo_data = 00 and busy = 0.
REQ-032 Reset mid-frame SHALL abort the frame, with txfifo_wr = 0 from the reset cycle and no completion of the partial frame.

Configuration
REQ-033 When macro TX_CHECKSUM_EN is defined, a checksum byte SHALL be inserted before 55, giving FRAME_LEN = 9.
REQ-034 With TX_CHECKSUM_EN, the checksum SHALL be the XOR of code[15:8], code[7:0] and the four data bytes.
REQ-035 With TX_CHECKSUM_EN, the space check in WAIT_SPACE SHALL use 9.
REQ-036 Without TX_CHECKSUM_EN, the frame SHALL be exactly REQ-015.

Structure
REQ-037 A shared protocol package SHALL hold FRAME_PREFIX = 8'hAA, FRAME_SUFFIX = 8'h55, FRAME_LEN and the message code constants (0001 phase set, 1ED0 error report).
REQ-038 The package SHALL also hold the FSM state enum type.
REQ-039 One sub-module, frame_serializer, SHALL map the index and the captured code/data to a byte, including the checksum.
REQ-040 The FSM, counter and handshake logic SHALL be in transmitter itself.

Verification
REQ-041 Send code=0001, data=00010305 with load=0 and full=0: wr for 8 consecutive cycles with bytes AA 00 01 00 01 03 05 55, starting 2 cycles after acceptance, and frames_sent=1.
REQ-042 load=DEPTH-7 at acceptance, then 0 after 5 cycles: the block stays in WAIT_SPACE with no wr for 5 cycles, then sends the full frame.
REQ-043 full asserted for 3 cycles after the 3rd byte: wr=0 for those cycles, then bytes 4-8 with no loss or duplication.
REQ-044 Reset asserted after the 4th byte: wr drops in the same cycle, msg_ready=1, frames_sent=0, and the next frame starts again at AA.
REQ-045 With TX_CHECKSUM_EN, code=1ED0 and data=00000001: the frame is AA 1E D0 00 00 00 01 CF 55.
REQ-046 65536 frames: frames_sent wraps to 0000.

Source files
------------

// File: rtl/transmitter_pkg.sv
// transmitter_pkg: shared framing constants, message codes, FSM state type,
// the captured-message payload struct and the checksum helper.
// Build option: define TX_CHECKSUM_EN to append an XOR checksum byte before
// the suffix, which stretches FRAME_LEN from 8 to 9.
package transmitter_pkg;

  // Byte-index width: enough to address up to 9 frame bytes.
  localparam int unsigned IDX_W = 4;

  localparam logic [7:0] FRAME_PREFIX = 8'hAA;
  localparam logic [7:0] FRAME_SUFFIX = 8'h55;

`ifdef TX_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = 9;
`else
  localparam int unsigned FRAME_LEN = 8;
`endif

  localparam logic [15:0] MSG_CODE_PHASE_SET    = 16'h0001;
  localparam logic [15:0] MSG_CODE_ERROR_REPORT = 16'h1ED0;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    SEND       = 2'd2
  } tx_state_e;

  // Message captured at acceptance and held for the whole frame.
  typedef struct packed {
    logic [15:0] code;
    logic [31:0] data;
  } msg_t;

  // XOR of the two code bytes and the four data bytes.
  function automatic logic [7:0] frame_checksum(input msg_t m);
    return m.code[15:8] ^ m.code[7:0] ^
           m.data[31:24] ^ m.data[23:16] ^ m.data[15:8] ^ m.data[7:0];
  endfunction

endpackage

// File: rtl/transmitter_if.sv
// transmitter_if: message handshake plus TX FIFO write/status signals.
//   msg_valid/msg_ready/msg_code/msg_data : message request handshake
//   txfifo_load/txfifo_full               : FIFO occupancy and full flag
//   txfifo_wr/txfifo_data                 : byte write port into the FIFO
// master = environment side, slave = transmitter side.
interface transmitter_if #(
  parameter int unsigned TX_FIFO_LOAD_W = 10
) ();

  logic                      msg_valid;
  logic                      msg_ready;
  logic [15:0]               msg_code;
  logic [31:0]               msg_data;
  logic [TX_FIFO_LOAD_W-1:0] txfifo_load;
  logic                      txfifo_full;
  logic                      txfifo_wr;
  logic [7:0]                txfifo_data;

  modport master (
    output msg_valid, msg_code, msg_data, txfifo_load, txfifo_full,
    input  msg_ready, txfifo_wr, txfifo_data
  );

  modport slave (
    input  msg_valid, msg_code, msg_data, txfifo_load, txfifo_full,
    output msg_ready, txfifo_wr, txfifo_data
  );

endinterface

// File: rtl/transmitter_frame_serializer.sv
// frame_serializer: selects the frame byte addressed by idx from the captured
// message. Purely combinational.
//   msg     : captured code/data
//   idx     : byte index within the frame
//   tx_byte : selected byte (00 for out-of-range indices)
// With TX_CHECKSUM_EN the checksum occupies index 7 and the suffix moves to 8.
module frame_serializer
  import transmitter_pkg::*;
(
  input  msg_t             msg,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       tx_byte
);

  always_comb begin
    tx_byte = 8'h00;
    case (idx)
      IDX_W'(0): tx_byte = FRAME_PREFIX;
      IDX_W'(1): tx_byte = msg.code[15:8];
      IDX_W'(2): tx_byte = msg.code[7:0];
      IDX_W'(3): tx_byte = msg.data[31:24];
      IDX_W'(4): tx_byte = msg.data[23:16];
      IDX_W'(5): tx_byte = msg.data[15:8];
      IDX_W'(6): tx_byte = msg.data[7:0];
`ifdef TX_CHECKSUM_EN
      IDX_W'(7): tx_byte = frame_checksum(msg);
      IDX_W'(8): tx_byte = FRAME_SUFFIX;
`else
      IDX_W'(7): tx_byte = FRAME_SUFFIX;
`endif
      default:   tx_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/transmitter.sv
// transmitter: accepts a code/data message, waits for enough TX FIFO space for
// a whole frame, then writes the frame one byte per cycle, stalling on full.
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : message handshake and TX FIFO port (see transmitter_if)
//   busy        : a frame is held or being sent
//   frames_sent : completed-frame count, wraps FFFF -> 0000
// Build option: TX_CHECKSUM_EN adds a checksum byte (9-byte frames).
// TX_FIFO_DEPTH must not exceed 2**TX_FIFO_LOAD_W.
module transmitter
  import transmitter_pkg::*;
#(
  parameter int unsigned TX_FIFO_LOAD_W = 10,
  parameter int unsigned TX_FIFO_DEPTH  = 512
) (
  input  logic        clk,
  input  logic        rst,
  transmitter_if.slave bus,
  output logic        busy,
  output logic [15:0] frames_sent
);

  // One extra bit so DEPTH - load never wraps.
  localparam int unsigned FREE_W = TX_FIFO_LOAD_W + 1;

  tx_state_e        state;
  msg_t             msg_q;
  logic [IDX_W-1:0] idx;
  logic [15:0]      frames_cnt;

  logic [FREE_W-1:0] depth_c;
  logic [FREE_W-1:0] load_c;
  logic [FREE_W-1:0] free_c;
  logic              space_ok_c;
  logic              wr_c;
  logic              last_c;
  logic [7:0]        byte_c;

  // Free-space check for a whole frame; an over-range load reads as no space.
  always_comb begin
    depth_c    = FREE_W'(TX_FIFO_DEPTH);
    load_c     = FREE_W'(bus.txfifo_load);
    free_c     = depth_c - load_c;
    space_ok_c = (load_c <= depth_c) && (free_c >= FREE_W'(FRAME_LEN)) &&
                 !bus.txfifo_full;
  end

  // Write strobe is combinational on full; rst kills it in the reset cycle.
  assign wr_c   = (state == SEND) && !bus.txfifo_full && !rst;
  assign last_c = wr_c && (idx == IDX_W'(FRAME_LEN - 1));

  // Control FSM, byte index, message capture and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      msg_q      <= '0;
      idx        <= '0;
      frames_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.msg_valid) begin
            msg_q <= '{code: bus.msg_code, data: bus.msg_data};
            idx   <= '0;
            state <= WAIT_SPACE;
          end
        end
        WAIT_SPACE: begin
          if (space_ok_c) state <= SEND;
        end
        SEND: begin
          if (last_c) begin
            idx        <= '0;
            frames_cnt <= frames_cnt + 16'd1;
            state      <= IDLE;
          end else if (wr_c) begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  frame_serializer u_ser (
    .msg     (msg_q),
    .idx     (idx),
    .tx_byte (byte_c)
  );

  // Reset overrides the state-derived handshake and status outputs.
  assign bus.msg_ready   = (state == IDLE) || rst;
  assign bus.txfifo_wr   = wr_c;
  assign bus.txfifo_data = wr_c ? byte_c : 8'h00;
  assign busy            = (state != IDLE) && !rst;
  assign frames_sent     = frames_cnt;

endmodule
